// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define ARB_BURST_LOCK_EN to compile in burst-lock (up to MAX_BURST consecutive words per owner).
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]         fifo_din_o,
   input  logic                          fifo_full_i,
   output logic [$clog2(NUM_REQ)-1:0]    last_owner_o,
   output logic                          locked_o,
   output logic [$clog2(NUM_REQ)-1:0]    dbg_rr_ptr_o,
   output logic [7:0]                    dbg_burst_cnt_o
);

   localparam int IW = $clog2(NUM_REQ);
   typedef logic [IW-1:0] idx_t;

   if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
      $error("fifo_wr_arbiter: parameter out of range");
   end

   // Handshake: req_i[i] is a valid that stays high with its word until gnt_o[i]
   // is seen high in the same cycle; gnt_o is the one-cycle accept, the FIFO is the only back-pressure.

   idx_t                  rr_ptr_q, rr_ptr_d;
   idx_t                  last_owner_q, last_owner_d;
   idx_t                  win_idx;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  grant;
   int                    cand;

`ifdef ARB_BURST_LOCK_EN
   localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);
   logic [7:0] burst_cnt_q, burst_cnt_d, cnt_new;
   logic       locked_q, locked_d;
`endif

   function automatic idx_t wrap_inc(input idx_t v);
      if (v == idx_t'(NUM_REQ-1)) return '0;
      return v + idx_t'(1);
   endfunction

   // Descending scan so the candidate closest to rr_ptr_q is the last (winning) assignment.
   always_comb begin
      win_idx = '0;
      cand    = 0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (req_i[idx_t'(cand)]) win_idx = idx_t'(cand);
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win_idx == idx_t'(i)) win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign grant = (|req_i) & ~fifo_full_i & ~rst;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         last_owner_q <= '0;
`ifdef ARB_BURST_LOCK_EN
         burst_cnt_q  <= '0;
         locked_q     <= 1'b0;
`endif
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         last_owner_q <= last_owner_d;
`ifdef ARB_BURST_LOCK_EN
         burst_cnt_q  <= burst_cnt_d;
         locked_q     <= locked_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      last_owner_d = last_owner_q;
`ifdef ARB_BURST_LOCK_EN
      burst_cnt_d  = burst_cnt_q;
      locked_d     = locked_q;
      cnt_new      = 8'd1;
`endif
      if (grant) begin
         last_owner_d = win_idx;
`ifdef ARB_BURST_LOCK_EN
         if (win_idx != last_owner_q || !locked_q) cnt_new = 8'd1;
         else                                      cnt_new = burst_cnt_q + 8'd1;
         if (cnt_new < MAX_B8) begin
            rr_ptr_d    = win_idx;
            burst_cnt_d = cnt_new;
            locked_d    = 1'b1;
         end else begin
            rr_ptr_d    = wrap_inc(win_idx);
            burst_cnt_d = 8'd0;
            locked_d    = 1'b0;
         end
`else
         rr_ptr_d = wrap_inc(win_idx);
`endif
      end
`ifdef ARB_BURST_LOCK_EN
      // Owner went idle with the FIFO able to take data: hand the port on.
      else if (locked_q && !fifo_full_i && !req_i[last_owner_q]) begin
         locked_d = 1'b0;
         rr_ptr_d = wrap_inc(last_owner_q);
      end
`endif
   end

   // Outputs
   always_comb begin
      gnt_o        = '0;
      fifo_wr_en_o = grant;
      fifo_din_o   = '0;
      if (grant) begin
         gnt_o      = NUM_REQ'(1) << win_idx;
         fifo_din_o = win_data;
      end
   end

   assign last_owner_o = last_owner_q;
   assign dbg_rr_ptr_o = rr_ptr_q;
`ifdef ARB_BURST_LOCK_EN
   assign locked_o        = locked_q;
   assign dbg_burst_cnt_o = burst_cnt_q;
`else
   assign locked_o        = 1'b0;
   assign dbg_burst_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vector tables, a reset-mid-burst sequence and random
// traffic checked against a rule-level reference model; follows ARB_BURST_LOCK_EN if defined.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
`ifdef ARB_BURST_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   // Clock / reset
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [DW-1:0] dat [N];
   logic [N*DW-1:0] req_data;
   logic          full = 1'b0;
   logic [N-1:0]  gnt;
   logic          wr_en;
   logic [DW-1:0] din;
   logic [1:0]    last_owner, rr_ptr;
   logic          locked;
   logic [7:0]    burst_cnt;

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
   end

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req_i(req), .req_data_i(req_data),
      .gnt_o(gnt), .fifo_wr_en_o(wr_en), .fifo_din_o(din), .fifo_full_i(full),
      .last_owner_o(last_owner), .locked_o(locked),
      .dbg_rr_ptr_o(rr_ptr), .dbg_burst_cnt_o(burst_cnt)
   );

   // Scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: arbitration rules as plain integer bookkeeping
   int m_ptr, m_owner, m_cnt;
   bit m_lck;

   function automatic void model_reset();
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_lck = 1'b0;
   endfunction

   function automatic int model_winner(input logic [N-1:0] r);
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic f);
      int w, nc;
      w = model_winner(r);
      if (w >= 0 && !f) begin
         if (LOCK) begin
            nc = (w != m_owner || !m_lck) ? 1 : m_cnt + 1;
            if (nc < MB) begin
               m_ptr = w; m_cnt = nc; m_lck = 1'b1;
            end else begin
               m_ptr = (w + 1) % N; m_cnt = 0; m_lck = 1'b0;
            end
         end else begin
            m_ptr = (w + 1) % N;
         end
         m_owner = w;
      end else if (LOCK && m_lck && !f && !r[m_owner]) begin
         m_lck = 1'b0;
         m_ptr = (m_owner + 1) % N;
      end
   endfunction

   // Driver: called just after a rising edge; checks mid-cycle, returns after the next edge
   task automatic apply(input logic [N-1:0] r, input logic f, input logic rs,
                        input bit use_t, input logic [N-1:0] tg, input logic [DW-1:0] td,
                        input logic tl, input string tag, output int gw);
      logic [N-1:0]  eg;
      logic [DW-1:0] ed;
      int w;
      req = r; full = f; rst = rs;
      if (rs) model_reset();
      @(negedge clk);
      w  = model_winner(r);
      gw = (w >= 0 && !f && !rs) ? w : -1;
      eg = '0; ed = '0;
      if (gw >= 0) begin
         eg = N'(1) << gw;
         ed = dat[gw];
         exp_q.push_back(ed);
      end
      chk({tag, ".gnt"},        32'(gnt),        32'(eg));
      chk({tag, ".wr_en"},      32'(wr_en),      32'(gw >= 0));
      chk({tag, ".din"},        32'(din),        32'(ed));
      chk({tag, ".last_owner"}, 32'(last_owner), 32'(m_owner));
      chk({tag, ".locked"},     32'(locked),     32'(m_lck));
      chk({tag, ".rr_ptr"},     32'(rr_ptr),     32'(m_ptr));
      chk({tag, ".burst_cnt"},  32'(burst_cnt),  32'(m_cnt));
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) chk({tag, ".sb_unexpected_write"}, 32'(din), 32'hFFFF_FFFF);
         else                   chk({tag, ".sb_word"}, 32'(din), 32'(exp_q.pop_front()));
      end
      if (use_t) begin
         chk({tag, ".tab_gnt"},    32'(gnt),    32'(tg));
         chk({tag, ".tab_din"},    32'(din),    32'(td));
         chk({tag, ".tab_locked"}, 32'(locked), 32'(tl));
      end
      @(posedge clk);
      #1;
      if (!rs) model_step(r, f);
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic          full;
      logic [N-1:0]  gnt;
      logic [DW-1:0] din;
      logic          lck;
   } vec_t;
   vec_t tab[$];

   function automatic void add(input logic [N-1:0] r, input logic f, input logic [N-1:0] g,
                               input logic [DW-1:0] d, input logic l);
      vec_t v;
      v.req = r; v.full = f; v.gnt = g; v.din = d; v.lck = l;
      tab.push_back(v);
   endfunction

   initial begin
      int gw;
      logic [N-1:0] r;
      logic f, rs;
      for (int i = 0; i < N; i++) dat[i] = 8'hA0 + 8'(i);
      model_reset();

`ifdef ARB_BURST_LOCK_EN
      add(4'b0011, 1'b0, 4'b0001, 8'hA0, 1'b0);
      add(4'b0011, 1'b0, 4'b0001, 8'hA0, 1'b1);
      add(4'b0011, 1'b0, 4'b0001, 8'hA0, 1'b1);
      add(4'b0011, 1'b0, 4'b0001, 8'hA0, 1'b1);
      add(4'b0011, 1'b0, 4'b0010, 8'hA1, 1'b0);
      add(4'b0011, 1'b0, 4'b0010, 8'hA1, 1'b1);
      add(4'b0001, 1'b0, 4'b0001, 8'hA0, 1'b1);
      add(4'b0110, 1'b1, 4'b0000, 8'h00, 1'b1);
      add(4'b0110, 1'b1, 4'b0000, 8'h00, 1'b1);
      add(4'b0110, 1'b0, 4'b0010, 8'hA1, 1'b1);
      add(4'b0000, 1'b0, 4'b0000, 8'h00, 1'b1);
      add(4'b0011, 1'b0, 4'b0001, 8'hA0, 1'b0);
`else
      add(4'b1111, 1'b0, 4'b0001, 8'hA0, 1'b0);
      add(4'b1111, 1'b0, 4'b0010, 8'hA1, 1'b0);
      add(4'b1111, 1'b0, 4'b0100, 8'hA2, 1'b0);
      add(4'b1111, 1'b0, 4'b1000, 8'hA3, 1'b0);
      add(4'b1111, 1'b0, 4'b0001, 8'hA0, 1'b0);
      add(4'b0110, 1'b1, 4'b0000, 8'h00, 1'b0);
      add(4'b0110, 1'b1, 4'b0000, 8'h00, 1'b0);
      add(4'b0110, 1'b1, 4'b0000, 8'h00, 1'b0);
      add(4'b0110, 1'b0, 4'b0010, 8'hA1, 1'b0);
      add(4'b0110, 1'b0, 4'b0100, 8'hA2, 1'b0);
      add(4'b1001, 1'b0, 4'b1000, 8'hA3, 1'b0);
      add(4'b1001, 1'b0, 4'b0001, 8'hA0, 1'b0);
      add(4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);
`endif

      // Reset with every requester asking
      apply(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h00, 1'b0, "reset", gw);

      foreach (tab[i])
         apply(tab[i].req, tab[i].full, 1'b0, 1'b1, tab[i].gnt, tab[i].din, tab[i].lck,
               $sformatf("tab%0d", i), gw);

      // Reset in the middle of a burst owned by requester 2
      apply(4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, "mid_rst0", gw);
      apply(4'b0100, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "burst2_a", gw);
      apply(4'b0100, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, "burst2_b", gw);
      chk("mid_burst_locked", 32'(locked), 32'(LOCK));
      apply(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, 8'h00, 1'b0, "mid_rst", gw);
      apply(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 8'hA2, 1'b0, "after_rst", gw);
      chk("after_rst_cnt", 32'(burst_cnt), LOCK ? 32'd1 : 32'd0);

      // Random traffic: held requests, random back-pressure, occasional reset
      r = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  r[i]   = 1'b1;
                  dat[i] = 8'($urandom_range(0, 255));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               r[i] = 1'b0;
            end
         end
         f  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 99) == 0);
         apply(r, f, rs, 1'b0, '0, '0, 1'b0, $sformatf("rnd%0d", c), gw);
         if (gw >= 0) r[gw] = 1'b0;
      end

      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
